// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, presents it to the instruction ROM,
// latches the returned word into the fetch register (IR), pre-decodes direct
// jumps and halt, and accepts redirects from downstream branch resolution.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 125,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] iRAMOutput,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  halted,
  output logic                  fault,
  output logic [15:0]           fetch_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
  localparam logic [5:0]  OP_JUMP   = 6'b010101;
  localparam logic [5:0]  OP_HLT    = 6'b011100;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [5:0]            opcode;
  logic                  pc_in_range;

  assign opcode      = iRAMOutput[31:26];
  assign pc_in_range = ({1'b0, pc_q} < CMP_WIDTH'(MEM_DEPTH));

  // Next-state and next-output selection: redirect > stall > state action
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    count_d    = count_q;

    if (redirect_valid) begin
      pc_d     = redirect_target;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      fault_d  = 1'b0;
      state_d  = ST_RUN;
    end else if (!stall) begin
      unique case (state_q)
        ST_RUN: begin
          if (!pc_in_range) begin
            valid_d  = 1'b0;
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            instr_d    = iRAMOutput;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            count_d    = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
            if (opcode == OP_JUMP) begin
              pc_d = ADDR_WIDTH'(iRAMOutput[9:0]);
            end else if (opcode == OP_HLT) begin
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end else begin
              pc_d = pc_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign address     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run, all checked against a program-level fetch model.
module tb_instruction_fetch_unit;

  localparam int unsigned AW        = 10;
  localparam int unsigned DW        = 32;
  localparam int unsigned MEM_DEPTH = 125;
  localparam logic [31:0] W_NOP     = 32'h0000_0000;
  localparam logic [31:0] W_ADDI    = 32'h2021_0005;
  localparam logic [31:0] W_SLT     = 32'h0022_182A;
  localparam logic [31:0] W_HLT     = 32'h7000_0000;
  localparam logic [31:0] W_JUMP81  = 32'h5400_0051;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] iRAMOutput;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;
  logic          fault;
  logic [15:0]   fetch_count;

  logic [31:0] rom [0:1023];

  int vectors    = 0;
  int miscompares = 0;

  // Program-level model of the architectural fetch state
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_instr;
  logic [AW-1:0] m_ipc;
  logic          m_valid, m_halted, m_fault;
  logic [15:0]   m_cnt;

  wire  [70:0] dut_vec = {address, instr, instr_pc, instr_valid, halted, fault, fetch_count};
  logic [70:0] mdl_vec;

  always_comb mdl_vec = {m_pc, m_instr, m_ipc, m_valid, m_halted, m_fault, m_cnt};

  assign iRAMOutput = rom[address];

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .address         (address),
    .iRAMOutput      (iRAMOutput),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  // Advance the model by one cycle from the current inputs, then clock the DUT
  task automatic step();
    logic [31:0] w;
    if (reset) begin
      m_pc = '0; m_instr = '0; m_ipc = '0;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_cnt = '0;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (int'(m_pc) >= int'(MEM_DEPTH)) begin
      m_valid = 1'b0; m_fault = 1'b1; m_halted = 1'b1;
    end else begin
      w = rom[m_pc];
      m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (w[31:26] == 6'b010101)      m_pc = w[9:0];
      else if (w[31:26] == 6'b011100) m_halted = 1'b1;
      else                             m_pc = m_pc + 10'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h2000_0000 | 32'(i);
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom();
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 10'd77;
    step();
    step();
    vectors++;
    if (dut_vec !== 71'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, 71'd0);
    end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    fill_rom();
    rom[0] = W_NOP; rom[1] = W_ADDI; rom[2] = W_SLT;
    apply_reset();
    vectors++;
    if ({address, instr_valid} !== {10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL seq_start: got addr=%0d valid=%b expected addr=0 valid=0", address, instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({instr_valid, instr_pc, instr, address} !== {1'b1, 10'(k), rom[k], 10'(k + 1)}) begin
        miscompares++;
        $display("FAIL seq_fetch%0d: got valid=%b pc=%0d instr=%h addr=%0d expected valid=1 pc=%0d instr=%h addr=%0d",
                 k, instr_valid, instr_pc, instr, address, k, rom[k], k + 1);
      end
    end
  endtask

  task automatic test_jump();
    fill_rom();
    rom[1] = W_JUMP81;
    apply_reset();
    step();
    step();
    vectors++;
    if ({instr, instr_pc, instr_valid, address} !== {W_JUMP81, 10'd1, 1'b1, 10'd81}) begin
      miscompares++;
      $display("FAIL jump_redirect: got instr=%h pc=%0d valid=%b addr=%0d expected instr=%h pc=1 valid=1 addr=81",
               instr, instr_pc, instr_valid, address, W_JUMP81);
    end
    step();
    vectors++;
    if ({instr_pc, instr_valid, address, fetch_count} !== {10'd81, 1'b1, 10'd82, 16'd3}) begin
      miscompares++;
      $display("FAIL jump_no_bubble: got pc=%0d valid=%b addr=%0d cnt=%0d expected pc=81 valid=1 addr=82 cnt=3",
               instr_pc, instr_valid, address, fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [15:0] held;
    fill_rom();
    apply_reset();
    redirect_valid = 1'b1; redirect_target = 10'd3;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    held = m_cnt;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({address, instr_pc, instr_valid, fetch_count} !== {10'd5, 10'd4, 1'b1, held}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got addr=%0d pc=%0d valid=%b cnt=%0d expected addr=5 pc=4 valid=1 cnt=%0d",
                 k, address, instr_pc, instr_valid, fetch_count, held);
      end
    end
    stall = 1'b0;
    for (int k = 5; k < 7; k++) begin
      step();
      vectors++;
      if ({instr_pc, instr_valid} !== {10'(k), 1'b1}) begin
        miscompares++;
        $display("FAIL stall_resume: got pc=%0d valid=%b expected pc=%0d valid=1", instr_pc, instr_valid, k);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] held;
    fill_rom();
    rom[123] = W_HLT;
    apply_reset();
    redirect_valid = 1'b1; redirect_target = 10'd123;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({instr_valid, address} !== {1'b0, 10'd123}) begin
      miscompares++;
      $display("FAIL halt_bubble: got valid=%b addr=%0d expected valid=0 addr=123", instr_valid, address);
    end
    step();
    held = fetch_count;
    vectors++;
    if ({instr, instr_valid, halted, address} !== {W_HLT, 1'b1, 1'b1, 10'd123}) begin
      miscompares++;
      $display("FAIL halt_latch: got instr=%h valid=%b halted=%b addr=%0d expected instr=%h valid=1 halted=1 addr=123",
               instr, instr_valid, halted, address, W_HLT);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({instr_valid, halted, address, fetch_count, instr_pc} !== {1'b0, 1'b1, 10'd123, held, 10'd123}) begin
        miscompares++;
        $display("FAIL halt_frozen%0d: got valid=%b halted=%b addr=%0d cnt=%0d expected valid=0 halted=1 addr=123 cnt=%0d",
                 k, instr_valid, halted, address, fetch_count, held);
      end
    end
    redirect_valid = 1'b1; redirect_target = 10'd2;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({halted, instr_valid, address} !== {1'b0, 1'b0, 10'd2}) begin
      miscompares++;
      $display("FAIL halt_exit: got halted=%b valid=%b addr=%0d expected halted=0 valid=0 addr=2",
               halted, instr_valid, address);
    end
    step();
    vectors++;
    if ({instr_pc, instr_valid} !== {10'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_rerun: got pc=%0d valid=%b expected pc=2 valid=1", instr_pc, instr_valid);
    end
  endtask

  task automatic test_redirect_stall();
    fill_rom();
    apply_reset();
    step();
    step();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 10'd22;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    vectors++;
    if ({instr_valid, address} !== {1'b0, 10'd22}) begin
      miscompares++;
      $display("FAIL redir_stall: got valid=%b addr=%0d expected valid=0 addr=22", instr_valid, address);
    end
    step();
    vectors++;
    if ({instr_pc, instr_valid, instr} !== {10'd22, 1'b1, rom[22]}) begin
      miscompares++;
      $display("FAIL redir_target: got pc=%0d valid=%b expected pc=22 valid=1", instr_pc, instr_valid);
    end
  endtask

  task automatic test_fault();
    fill_rom();
    apply_reset();
    for (int k = 0; k < 125; k++) begin
      step();
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL fault_walk%0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    vectors++;
    if ({instr_pc, instr_valid, fault, address, fetch_count} !== {10'd124, 1'b1, 1'b0, 10'd125, 16'd125}) begin
      miscompares++;
      $display("FAIL fault_last: got pc=%0d valid=%b fault=%b addr=%0d cnt=%0d expected pc=124 valid=1 fault=0 addr=125 cnt=125",
               instr_pc, instr_valid, fault, address, fetch_count);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({fault, halted, instr_valid, address, instr_pc} !== {1'b1, 1'b1, 1'b0, 10'd125, 10'd124}) begin
        miscompares++;
        $display("FAIL fault_set%0d: got fault=%b halted=%b valid=%b addr=%0d expected fault=1 halted=1 valid=0 addr=125",
                 k, fault, halted, instr_valid, address);
      end
    end
    redirect_valid = 1'b1; redirect_target = 10'd0;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({fault, halted, address} !== {1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL fault_clear: got fault=%b halted=%b addr=%0d expected fault=0 halted=0 addr=0",
               fault, halted, address);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      case ($urandom_range(0, 19))
        0: w = {6'b010101, 16'($urandom), 10'($urandom_range(0, 130))};
        1: w = W_HLT | 32'($urandom_range(0, 255));
        default: begin
          w = $urandom;
          if (w[31:26] == 6'b010101 || w[31:26] == 6'b011100) w[31:26] = 6'b000000;
        end
      endcase
      rom[i] = w;
    end
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      reset           = ($urandom_range(0, 299) == 0);
      stall           = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 24) == 0);
      redirect_target = 10'($urandom_range(0, 130));
      step();
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL random%0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_rom();
    apply_reset();
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 10'd50;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    vectors++;
    if (dut_vec !== 71'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected %h", dut_vec, 71'd0);
    end
    step();
    vectors++;
    if ({instr_pc, instr_valid, fetch_count, address} !== {10'd0, 1'b1, 16'd1, 10'd1}) begin
      miscompares++;
      $display("FAIL reset_restart: got pc=%0d valid=%b cnt=%0d addr=%0d expected pc=0 valid=1 cnt=1 addr=1",
               instr_pc, instr_valid, fetch_count, address);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_halt();
    test_redirect_stall();
    test_fault();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
